// File: rtl/multi_step_gen.sv
// -----------------------------------------------------------------------------
// multi_step_gen
//
// Purpose: N_CH independent step/direction pulse generators. Each channel takes
// a move command (speed in steps/s, step count, direction), derives the step
// period K/speed with a serial restoring divider, then emits the requested
// number of step pulses. A move can be aborted at any point after acceptance.
//
// Ports:
//   clock_in     single clock, all state changes on its rising edge
//   reset_n      asynchronous active-low reset
//   cmd_valid    per-channel command request
//   cmd_ready    per-channel ready (high only while the channel is IDLE)
//   cmd_speed    channel i speed at [i*SPEED_W +: SPEED_W], steps/s
//   cmd_steps    channel i step count at [i*STEP_W +: STEP_W]
//   cmd_dir      requested direction
//   abort        stop the channel's move (ignored while IDLE)
//   step_out     step pulses, PULSE_W cycles high per step
//   dir_out      direction registered at command acceptance
//   busy         high while the channel is in CALC or RUN
//   done         one-cycle completion pulse
//   aborted      qualifies done: high together with done after an abort
//   dbg_state_o  channel i FSM state at [2*i +: 2] (0 IDLE, 1 CALC, 2 RUN)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high for that channel. cmd_valid may be raised at any
// time and carries no obligation to hold; cmd_ready depends only on the
// channel's own state, never on cmd_valid.
// -----------------------------------------------------------------------------
module multi_step_gen #(
   parameter int N_CH    = 2,
   parameter int SPEED_W = 32,
   parameter int STEP_W  = 16,
   parameter int CNT_W   = 28,
   parameter int K       = 100000000,
   parameter int PULSE_W = 11
) (
   input  logic                      clock_in,
   input  logic                      reset_n,
   input  logic [N_CH-1:0]           cmd_valid,
   output logic [N_CH-1:0]           cmd_ready,
   input  logic [N_CH*SPEED_W-1:0]   cmd_speed,
   input  logic [N_CH*STEP_W-1:0]    cmd_steps,
   input  logic [N_CH-1:0]           cmd_dir,
   input  logic [N_CH-1:0]           abort,
   output logic [N_CH-1:0]           step_out,
   output logic [N_CH-1:0]           dir_out,
   output logic [N_CH-1:0]           busy,
   output logic [N_CH-1:0]           done,
   output logic [N_CH-1:0]           aborted,
   output logic [2*N_CH-1:0]         dbg_state_o
);

   localparam int DW = CNT_W + SPEED_W;      // divider working width
   localparam int CW = $clog2(SPEED_W + 1);  // CALC cycle counter width

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(2 * PULSE_W);
   localparam logic [CNT_W-1:0] PW_C      = CNT_W'(PULSE_W);
   localparam logic [CNT_W-1:0] K_C       = CNT_W'(K);
   localparam logic [CW-1:0]    CALC_LAST = CW'(SPEED_W - 1);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch

      logic [1:0]         state_q, state_d;
      logic               ready_q, ready_d;
      logic               step_q, step_d;
      logic               dir_q, dir_d;
      logic               done_q, done_d;
      logic               abrt_q, abrt_d;
      logic [STEP_W-1:0]  steps_q, steps_d;
      logic [CNT_W-1:0]   period_q, period_d;
      logic [CNT_W-1:0]   cnt_q, cnt_d;
      logic [CNT_W-1:0]   rem_q, rem_d;
      logic [DW-1:0]      div_q, div_d;
      logic [SPEED_W-1:0] quot_q, quot_d;
      logic [CW-1:0]      calc_q, calc_d;

      logic [SPEED_W-1:0] spd;
      logic [STEP_W-1:0]  stp;
      logic               accept;
      logic               div_ge;
      logic [CNT_W-1:0]   rem_nx;
      logic [SPEED_W-1:0] quot_nx;
      logic               ovf;
      logic [CNT_W-1:0]   quot_cnt;

      always_comb begin
         state_d  = state_q;
         step_d   = step_q;
         dir_d    = dir_q;
         done_d   = 1'b0;
         abrt_d   = 1'b0;
         steps_d  = steps_q;
         period_d = period_q;
         cnt_d    = cnt_q;
         rem_d    = rem_q;
         div_d    = div_q;
         quot_d   = quot_q;
         calc_d   = calc_q;

         spd    = cmd_speed[g*SPEED_W +: SPEED_W];
         stp    = cmd_steps[g*STEP_W +: STEP_W];
         // ready_q is only ever high in IDLE, so it alone qualifies acceptance
         accept = cmd_valid[g] & ready_q;

         // One restoring-division step: div_q holds speed shifted to the
         // quotient bit being resolved, walking from MSB down to bit 0.
         div_ge  = (DW'(rem_q) >= div_q);
         rem_nx  = div_ge ? CNT_W'(DW'(rem_q) - div_q) : rem_q;
         quot_nx = (quot_q << 1) | SPEED_W'(div_ge);
         // On the final step div_q equals speed; a leftover remainder that is
         // still >= speed means the quotient did not fit in SPEED_W bits
         // (only possible when SPEED_W < CNT_W). Saturate in that case.
         ovf      = (DW'(rem_nx) >= div_q);
         quot_cnt = CNT_W'(quot_nx);

         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  dir_d   = cmd_dir[g];
                  steps_d = stp;
                  if ((spd == '0) || (stp == '0)) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = ST_CALC;
                     calc_d  = '0;
                     rem_d   = K_C;
                     quot_d  = '0;
                     div_d   = DW'(spd) << (SPEED_W - 1);
                     cnt_d   = '0;
                  end
               end
            end

            ST_CALC: begin
               if (abort[g]) begin
                  state_d = ST_IDLE;
                  step_d  = 1'b0;
                  done_d  = 1'b1;
                  abrt_d  = 1'b1;
               end else begin
                  rem_d  = rem_nx;
                  quot_d = quot_nx;
                  div_d  = div_q >> 1;
                  calc_d = calc_q + CW'(1);
                  if (calc_q == CALC_LAST) begin
                     state_d = ST_RUN;
                     step_d  = 1'b1;
                     cnt_d   = '0;
                     if (ovf) begin
                        period_d = '1;
                     end else if (quot_cnt < MIN_P) begin
                        period_d = MIN_P;
                     end else begin
                        period_d = quot_cnt;
                     end
                  end
               end
            end

            ST_RUN: begin
               if (abort[g]) begin
                  state_d = ST_IDLE;
                  step_d  = 1'b0;
                  done_d  = 1'b1;
                  abrt_d  = 1'b1;
               end else if (cnt_q == (period_q - CNT_W'(1))) begin
                  // end of a full period: one step completed
                  steps_d = steps_q - STEP_W'(1);
                  if (steps_q == STEP_W'(1)) begin
                     state_d = ST_IDLE;
                     step_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     cnt_d  = '0;
                     step_d = 1'b1;
                  end
               end else begin
                  cnt_d  = cnt_q + CNT_W'(1);
                  step_d = ((cnt_q + CNT_W'(1)) < PW_C);
               end
            end

            default: begin
               state_d = ST_IDLE;
               step_d  = 1'b0;
            end
         endcase

         // Registered so that ready stays low through reset and rises on the
         // first edge after release.
         ready_d = (state_d == ST_IDLE);
      end

      always_ff @(posedge clock_in or negedge reset_n) begin
         if (!reset_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            abrt_q   <= 1'b0;
            steps_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quot_q   <= '0;
            calc_q   <= '0;
         end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            abrt_q   <= abrt_d;
            steps_q  <= steps_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quot_q   <= quot_d;
            calc_q   <= calc_d;
         end
      end

      assign cmd_ready[g]        = ready_q;
      assign step_out[g]         = step_q;
      assign dir_out[g]          = dir_q;
      assign busy[g]             = (state_q == ST_CALC) || (state_q == ST_RUN);
      assign done[g]             = done_q;
      assign aborted[g]          = abrt_q;
      assign dbg_state_o[2*g +: 2] = state_q;

   end

endmodule

// File: tb/tb_multi_step_gen.sv
// -----------------------------------------------------------------------------
// tb_multi_step_gen
//
// Bench for multi_step_gen with N_CH=2, SPEED_W=16, STEP_W=16, K=1000,
// PULSE_W=3. Each accepted command pushes its full event schedule (step rises,
// step falls, done / done+aborted, each tagged with the clock edge after which
// it is visible) into a per-channel expected queue; a monitor on the falling
// clock edge pops and compares every event the DUT actually produces.
// -----------------------------------------------------------------------------
module tb_multi_step_gen;

   localparam int NC  = 2;
   localparam int SW  = 16;
   localparam int TW  = 16;
   localparam int KK  = 1000;
   localparam int PW  = 3;
   localparam int LAT = SW;   // edges from accept to the edge raising step_out

   // ---------------- clock / reset ----------------
   logic clock_in;
   logic reset_n;

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   logic [NC-1:0]    cmd_valid;
   logic [NC-1:0]    cmd_ready;
   logic [NC*SW-1:0] cmd_speed;
   logic [NC*TW-1:0] cmd_steps;
   logic [NC-1:0]    cmd_dir;
   logic [NC-1:0]    abort;
   logic [NC-1:0]    step_out;
   logic [NC-1:0]    dir_out;
   logic [NC-1:0]    busy;
   logic [NC-1:0]    done;
   logic [NC-1:0]    aborted;
   logic [2*NC-1:0]  dbg_state;

   multi_step_gen #(
      .N_CH(NC), .SPEED_W(SW), .STEP_W(TW), .CNT_W(28), .K(KK), .PULSE_W(PW)
   ) dut (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_speed  (cmd_speed),
      .cmd_steps  (cmd_steps),
      .cmd_dir    (cmd_dir),
      .abort      (abort),
      .step_out   (step_out),
      .dir_out    (dir_out),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .dbg_state_o(dbg_state)
   );

   // index of the most recent rising edge
   int cyc = 0;
   always @(posedge clock_in) cyc <= cyc + 1;

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   // event = {kind[2:0], edge[31:0]}; kind 001 rise, 010 fall, 1ad done/aborted
   logic [34:0] exp_q[NC][$];
   int s_start[NC];
   int s_p[NC];
   int s_n[NC];
   int s_end[NC];

   function automatic int period_of(input int spd);
      int q;
      q = KK / spd;
      return (q < 2 * PW) ? 2 * PW : q;
   endfunction

   function automatic bit high_at(input int c, input int e);
      int d;
      if (s_n[c] == 0 || e < s_start[c]) return 1'b0;
      d = e - s_start[c];
      return ((d / s_p[c]) < s_n[c]) && ((d % s_p[c]) < PW);
   endfunction

   task automatic push_sched(input int c, input int t, input int spd, input int n);
      if (spd == 0 || n == 0) begin
         exp_q[c].push_back({3'b101, 32'(t)});
         s_n[c]   = 0;
         s_end[c] = t;
      end else begin
         s_p[c]     = period_of(spd);
         s_start[c] = t + LAT;
         s_n[c]     = n;
         for (int k = 0; k < n; k++) begin
            exp_q[c].push_back({3'b001, 32'(s_start[c] + k * s_p[c])});
            exp_q[c].push_back({3'b010, 32'(s_start[c] + k * s_p[c] + PW)});
         end
         s_end[c] = s_start[c] + n * s_p[c];
         exp_q[c].push_back({3'b101, 32'(s_end[c])});
      end
   endtask

   task automatic pop_cmp(input int c, input logic [34:0] ev);
      logic [34:0] e;
      if (exp_q[c].size() > 0) e = exp_q[c].pop_front();
      else e = '1;
      check_val((c == 0) ? "event_ch0" : "event_ch1", 64'(ev), 64'(e));
   endtask

   logic [NC-1:0] prev_step = '0;
   logic [34:0]   mon_ev;
   always @(negedge clock_in) begin
      if (!reset_n) begin
         prev_step = step_out;
      end else begin
         for (int c = 0; c < NC; c++) begin
            if (step_out[c] !== prev_step[c]) begin
               mon_ev = {(step_out[c] ? 3'b001 : 3'b010), 32'(cyc)};
               pop_cmp(c, mon_ev);
            end
            if (done[c] || aborted[c]) begin
               mon_ev = {1'b1, aborted[c], done[c], 32'(cyc)};
               pop_cmp(c, mon_ev);
            end
         end
         prev_step = step_out;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clock_in);
      #1;
   endtask

   task automatic set_cmd(input int c, input int spd, input int n, input bit d);
      check_val("ready_before_cmd", 64'(cmd_ready[c]), 64'd1);
      cmd_speed[c*SW +: SW] = SW'(spd);
      cmd_steps[c*TW +: TW] = TW'(n);
      cmd_dir[c]   = d;
      cmd_valid[c] = 1'b1;
      push_sched(c, cyc + 1, spd, n);
   endtask

   // Raise abort for the next edge; if the channel is mid-move the remaining
   // schedule is replaced by (optional fall) + done/aborted on that edge.
   task automatic abort_set(input int c);
      int a;
      a = cyc + 1;
      if (s_end[c] > cyc && cyc >= s_end[c] - (s_n[c] * s_p[c]) - LAT && s_n[c] != 0) begin
         while (exp_q[c].size() > 0 && int'(exp_q[c][exp_q[c].size()-1][31:0]) >= a)
            void'(exp_q[c].pop_back());
         if (high_at(c, cyc)) exp_q[c].push_back({3'b010, 32'(a)});
         exp_q[c].push_back({3'b111, 32'(a)});
         s_n[c]   = 0;
         s_end[c] = a;
      end
      abort[c] = 1'b1;
   endtask

   task automatic release_inputs();
      cmd_valid = '0;
      abort     = '0;
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while ((exp_q[0].size() + exp_q[1].size()) != 0 && k < budget) begin
         tick();
         k++;
      end
      check_val("drain", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
      repeat (3) tick();
   endtask

   task automatic run_ref_move();
      set_cmd(0, 100, 3, 1'b1);
      tick();
      release_inputs();
      // speed change while the divider is running must not matter
      cmd_speed[0 +: SW] = SW'(7);
      check_val("dir0_at_accept", 64'(dir_out[0]), 64'd1);
      check_val("busy0_calc", 64'(busy[0]), 64'd1);
      check_val("ready0_low", 64'(cmd_ready[0]), 64'd0);
      drain(200);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int t;
      int w;
      reset_n   = 1'b0;
      cmd_valid = '0;
      cmd_speed = '0;
      cmd_steps = '0;
      cmd_dir   = '0;
      abort     = '0;
      for (int c = 0; c < NC; c++) begin
         s_n[c] = 0; s_p[c] = 1; s_start[c] = 0; s_end[c] = 0;
      end

      // reset state
      repeat (2) tick();
      check_val("rst_ready", 64'(cmd_ready), 64'd0);
      check_val("rst_step", 64'(step_out), 64'd0);
      check_val("rst_dir", 64'(dir_out), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'({done, aborted}), 64'd0);
      check_val("rst_state", 64'(dbg_state), 64'd0);
      reset_n = 1'b1;
      tick();
      check_val("ready_after_rst", 64'(cmd_ready), 64'd3);

      // reference move on ch0
      run_ref_move();

      // clamped period on ch1; ch0 direction must hold
      set_cmd(1, 400, 4, 1'b0);
      tick();
      release_inputs();
      check_val("busy1", 64'(busy), 64'd2);
      check_val("dir_hold", 64'(dir_out), 64'd1);
      drain(200);

      // zero speed / zero steps: immediate done, never busy
      set_cmd(0, 0, 5, 1'b0);
      set_cmd(1, 50, 0, 1'b1);
      tick();
      release_inputs();
      check_val("zero_busy", 64'(busy), 64'd0);
      check_val("zero_dir", 64'(dir_out), 64'd2);
      check_val("zero_ready", 64'(cmd_ready), 64'd3);
      drain(20);

      // both channels on the same edge, different periods (8 and 33)
      set_cmd(0, 125, 2, 1'b0);
      set_cmd(1, 30, 2, 1'b1);
      tick();
      release_inputs();
      check_val("both_busy", 64'(busy), 64'd3);
      drain(300);

      // abort ch0 in its 2nd pulse-high cycle, ch1 keeps running
      set_cmd(0, 100, 4, 1'b1);
      set_cmd(1, 250, 5, 1'b0);
      tick();
      release_inputs();
      t = cyc;
      while (cyc < t + LAT + 1) tick();
      check_val("pre_abort_step0", 64'(step_out[0]), 64'd1);
      abort_set(0);
      tick();
      release_inputs();
      check_val("abort_step0", 64'(step_out[0]), 64'd0);
      check_val("abort_ready0", 64'(cmd_ready[0]), 64'd1);
      check_val("abort_busy", 64'(busy), 64'd2);
      drain(200);

      // abort in IDLE ignored; abort + command on the same IDLE edge accepted
      abort_set(1);
      abort_set(0);
      set_cmd(0, 200, 2, 1'b1);
      tick();
      release_inputs();
      check_val("abort_idle_busy", 64'(busy), 64'd1);
      drain(200);

      // randomized moves with occasional aborts
      for (int r = 0; r < 6; r++) begin
         set_cmd(0, $urandom_range(20, 600), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
         set_cmd(1, $urandom_range(20, 600), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
         tick();
         release_inputs();
         if ($urandom_range(0, 1) == 1) begin
            w = $urandom_range(0, 60);
            repeat (w) tick();
            abort_set($urandom_range(0, 1));
            tick();
            release_inputs();
         end
         drain(500);
      end

      // reset in the middle of a pulse, then the reference move again
      set_cmd(0, 100, 3, 1'b1);
      tick();
      release_inputs();
      t = cyc;
      while (cyc < t + LAT + 1) tick();
      check_val("pre_rst_step", 64'(step_out[0]), 64'd1);
      reset_n = 1'b0;
      #1;
      check_val("async_rst_step", 64'(step_out), 64'd0);
      check_val("async_rst_busy", 64'(busy), 64'd0);
      check_val("async_rst_misc", 64'({dir_out, done, aborted, cmd_ready}), 64'd0);
      for (int c = 0; c < NC; c++) begin
         exp_q[c].delete();
         s_n[c] = 0;
      end
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      check_val("ready_after_rst2", 64'(cmd_ready), 64'd3);
      run_ref_move();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
